// File: rtl/seqcheck_ctrl.sv
// Run controller for the serial sequence checker.
// Holds a shadow copy of the pattern, length and window configuration.
// A run samples cfg_win serial bits and counts overlapping pattern matches.
// It reports the match count and the index of the first match.
module seqcheck_ctrl #(
   parameter int PAT_W = 6,
   parameter int WIN_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [2:0]       cfg_len,
   input  logic [WIN_W-1:0] cfg_win,
   input  logic             start,
   input  logic             in,
   output logic             busy,
   output logic             done,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [WIN_W-1:0] first_pos,
   output logic [PAT_W-1:0] state,
   output logic             cfg_err
);

   localparam int FW = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t             fsm;
   logic [PAT_W-1:0] sh_pat, run_pat;
   logic [2:0]       sh_len, run_len;
   logic [WIN_W-1:0] sh_win, run_win;
   logic [WIN_W-1:0] k;
   logic [FW-1:0]    fill;

   logic [PAT_W-1:0] shifted;
   logic [PAT_W-1:0] mask;
   logic             hit;
   logic             new_cfg_bad;

   // Next shift-register value and overlapping-match detection for the current bit
   always_comb begin
      shifted = {state[PAT_W-2:0], in};
      mask    = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         mask[i] = (i < 32'(run_len));
      end
      hit = (((shifted ^ run_pat) & mask) == '0) && ((int'(fill) + 1) >= int'(run_len));
   end

   // Legality of the configuration being written this cycle
   always_comb begin
      new_cfg_bad = (cfg_len == 3'd0) || (int'(cfg_len) > PAT_W) || (cfg_win == '0);
   end

   // Control FSM with registered outputs.
   // The run works from private copies of the config taken when start is accepted,
   // so a cfg_we coinciding with start updates the shadow copy but not that run.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         first_pos <= '1;
         state     <= '0;
         fill      <= '0;
         k         <= '0;
         sh_pat    <= '0;
         sh_len    <= 3'd1;
         sh_win    <= WIN_W'(1);
         run_pat   <= '0;
         run_len   <= 3'd1;
         run_win   <= WIN_W'(1);
         cfg_err   <= 1'b0;
      end else begin
         match <= 1'b0;
         done  <= 1'b0;
         case (fsm)
            IDLE: begin
               if (cfg_we) begin
                  sh_pat  <= cfg_pattern;
                  sh_len  <= cfg_len;
                  sh_win  <= cfg_win;
                  cfg_err <= new_cfg_bad;
               end
               if (start && !cfg_err) begin
                  run_pat   <= sh_pat;
                  run_len   <= sh_len;
                  run_win   <= sh_win;
                  state     <= '0;
                  fill      <= '0;
                  match_cnt <= '0;
                  first_pos <= '1;
                  k         <= '0;
                  busy      <= 1'b1;
                  fsm       <= RUN;
               end
            end
            RUN: begin
               state <= shifted;
               if (fill != FW'(PAT_W)) begin
                  fill <= fill + 1'b1;
               end
               if (hit) begin
                  match <= 1'b1;
                  if (match_cnt != '1) begin
                     match_cnt <= match_cnt + 1'b1;
                  end
                  if (first_pos == '1) begin
                     first_pos <= k;
                  end
               end
               if (k == run_win - 1'b1) begin
                  busy <= 1'b0;
                  fsm  <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               done <= 1'b1;
               fsm  <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seqcheck_ctrl.sv
// Testbench for seqcheck_ctrl: directed runs with a done-driven scoreboard.
// A second instance with a 4-bit counter shares all stimulus to observe saturation.
module tb_seqcheck_ctrl;

   logic       clk = 1'b0;
   logic       rst, cfg_we, start, din;
   logic [5:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic [7:0] cfg_win;

   logic       busy, done, match, cfg_err;
   logic [7:0] match_cnt, first_pos;
   logic [5:0] state;

   logic       busy4, done4, match4, cfg_err4;
   logic [3:0] match_cnt4;
   logic [7:0] first_pos4;
   logic [5:0] state4;

   seqcheck_ctrl #(.PAT_W(6), .WIN_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_win(cfg_win), .start(start), .in(din),
      .busy(busy), .done(done), .match(match), .match_cnt(match_cnt),
      .first_pos(first_pos), .state(state), .cfg_err(cfg_err)
   );

   seqcheck_ctrl #(.PAT_W(6), .WIN_W(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_win(cfg_win), .start(start), .in(din),
      .busy(busy4), .done(done4), .match(match4), .match_cnt(match_cnt4),
      .first_pos(first_pos4), .state(state4), .cfg_err(cfg_err4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int cnt;
      int cnt4;
      int fp;
      int pulses;
      int busyc;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: tallies match pulses and busy cycles, checks results on each done
   initial begin
      int   pulses;
      int   busyc;
      exp_t e;
      pulses = 0;
      busyc  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pulses = 0;
            busyc  = 0;
         end else begin
            if (match) pulses++;
            if (busy)  busyc++;
            if (done) begin
               if (q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("match_cnt",   int'(match_cnt),  e.cnt);
                  chk("match_cnt4",  int'(match_cnt4), e.cnt4);
                  chk("first_pos",   int'(first_pos),  e.fp);
                  chk("match_pulses", pulses,          e.pulses);
                  chk("busy_cycles", busyc,            e.busyc);
                  chk("done4",       int'(done4),      1);
               end
               pulses = 0;
               busyc  = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [5:0] p, input logic [2:0] l, input logic [7:0] w);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_win     = w;
      cfg_we      = 1'b1;
      cyc(1);
      cfg_we      = 1'b0;
   endtask

   // One run of n bits; inj_k >= 0 drives cfg_we and start while bit inj_k is sampled
   task automatic run(input logic [63:0] bits, input int n, input int cnt, input int fp,
                      input int pulses, input int inj_k);
      exp_t e;
      e.cnt    = cnt;
      e.cnt4   = (cnt > 15) ? 15 : cnt;
      e.fp     = fp;
      e.pulses = pulses;
      e.busyc  = n;
      q.push_back(e);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         din = bits[i];
         if (i == inj_k) begin
            cfg_pattern = 6'd0;
            cfg_len     = 3'd2;
            cfg_win     = 8'd3;
            cfg_we      = 1'b1;
            start       = 1'b1;
         end
         cyc(1);
         cfg_we = 1'b0;
         start  = 1'b0;
      end
      din = 1'b0;
      cyc(3);
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; start = 1'b0; din = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_win = '0;
      cyc(2);
      rst = 1'b0;

      // reset state
      chk("rst_busy",      int'(busy),      0);
      chk("rst_done",      int'(done),      0);
      chk("rst_match",     int'(match),     0);
      chk("rst_match_cnt", int'(match_cnt), 0);
      chk("rst_first_pos", int'(first_pos), 255);
      chk("rst_state",     int'(state),     0);
      chk("rst_cfg_err",   int'(cfg_err),   0);

      // reset config pattern=0 len=1 win=1: a single 0 bit matches at k=0
      run(64'h0, 1, 1, 0, 1, -1);

      // test 1: 101, overlapping hits at k=4,6,9,11
      write_cfg(6'b000101, 3'd3, 8'd12);
      run(64'hAD4, 12, 4, 4, 4, -1);
      chk("t1_state", int'(state), 6'b110101);

      // test 2: full-width pattern, exactly filled and one bit short
      write_cfg(6'b110110, 3'd6, 8'd6);
      run(64'h1B, 6, 1, 5, 1, -1);
      write_cfg(6'b110110, 3'd6, 8'd5);
      run(64'h1B, 5, 0, 255, 0, -1);

      // test 3: every bit matches; 4-bit counter saturates at 15
      write_cfg(6'b000001, 3'd1, 8'd20);
      run(64'hFFFFF, 20, 20, 0, 20, -1);

      // test 4: reset after k=0..2 of a win=10 run
      write_cfg(6'b000001, 3'd1, 8'd10);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      din   = 1'b1;
      cyc(3);
      chk("t4_cnt_before_rst", int'(match_cnt), 3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      din = 1'b0;
      chk("t4_busy",      int'(busy),      0);
      chk("t4_match_cnt", int'(match_cnt), 0);
      chk("t4_state",     int'(state),     0);
      chk("t4_first_pos", int'(first_pos), 255);
      cyc(12);
      chk("t4_done",      int'(done),      0);
      write_cfg(6'b000101, 3'd3, 8'd12);
      run(64'hAD4, 12, 4, 4, 4, -1);

      // test 5: illegal length refuses start; cfg_we with start uses old config
      write_cfg(6'b000011, 3'd0, 8'd4);
      chk("t5_cfg_err", int'(cfg_err), 1);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("t5_busy_a", int'(busy), 0);
      cyc(2);
      chk("t5_busy_b", int'(busy), 0);
      cfg_pattern = 6'b000011;
      cfg_len     = 3'd2;
      cfg_win     = 8'd4;
      cfg_we      = 1'b1;
      start       = 1'b1;
      cyc(1);
      cfg_we = 1'b0;
      start  = 1'b0;
      chk("t5_busy_c",     int'(busy),    0);
      chk("t5_cfg_err_ok", int'(cfg_err), 0);
      cyc(2);
      chk("t5_busy_d",     int'(busy),    0);
      run(64'h7, 4, 2, 1, 2, -1);

      // test 6: cfg_we and start during RUN are ignored
      write_cfg(6'b000001, 3'd1, 8'd8);
      run(64'h55, 8, 4, 0, 4, 2);
      run(64'h55, 8, 4, 0, 4, -1);

      cyc(2);
      chk("sb_pending", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
